// File: rtl/tdoa_angle_estimator.sv
// rtl/tdoa_angle_estimator.sv - two-channel onset lag to 0..180 bearing with UART handshake
module tdoa_angle_estimator #(
  parameter logic [12:0] CALIB_L  = 13'd7296,
  parameter logic [12:0] CALIB_R  = 13'd7040,
  parameter logic [17:0] THRESH   = 18'd2000,
  parameter int          LAG_BITS = 4,
  parameter int          HOLDOFF  = 4096
) (
  input  logic        clock_i,
  input  logic        reset_i,
  input  logic [17:0] data_l_i,
  input  logic        data_rdy_l_i,
  input  logic [17:0] data_r_i,
  input  logic        data_rdy_r_i,
  input  logic        tx_busy_i,
  output logic [7:0]  angle_o,
  output logic        angle_rdy_o,
  output logic        active_o
);

  localparam int CNT_W  = LAG_BITS + 1;
  localparam int HOLD_W = $clog2(HOLDOFF + 1);
  localparam int PROD_W = CNT_W + 7;
  localparam logic [CNT_W-1:0]  MAX_LAG   = {1'b1, {LAG_BITS{1'b0}}};
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLDOFF - 1);

  typedef enum logic [2:0] {IDLE, WAIT_R, WAIT_L, COMPUTE, SEND, HOLD} state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    lag_q;
  logic [HOLD_W-1:0]   hold_q;
  logic                left_first_q;
  logic [7:0]          angle_q;
  logic                onset_l_q, onset_r_q, tick_q;

  logic [17:0]         mag_l, mag_r;
  logic [PROD_W-1:0]   prod;
  logic [7:0]          off;
  logic [7:0]          angle_d;
  logic                second_onset;

  // |sample - calib| in 19 bits, saturated to 18; wraparound arithmetic gives the two's complement bits
  function automatic logic [17:0] mag_f(input logic [17:0] data, input logic [12:0] calib);
    logic [18:0] diff;
    logic [18:0] absd;
    diff  = {1'b0, data} - {6'b0, calib};
    absd  = diff[18] ? (~diff + 19'd1) : diff;
    mag_f = absd[18] ? 18'h3ffff : absd[17:0];
  endfunction

  assign mag_l = mag_f(data_l_i, CALIB_L);
  assign mag_r = mag_f(data_r_i, CALIB_R);

  // Onset detection and the left sample tick, registered together so they stay aligned
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      onset_l_q <= 1'b0;
      onset_r_q <= 1'b0;
      tick_q    <= 1'b0;
    end else begin
      onset_l_q <= data_rdy_l_i && (mag_l >= THRESH);
      onset_r_q <= data_rdy_r_i && (mag_r >= THRESH);
      tick_q    <= data_rdy_l_i;
    end
  end

  // lag*90 >> LAG_BITS via shift-add, then fold around broadside by arrival order
  always_comb begin
    prod    = (PROD_W'(lag_q) << 6) + (PROD_W'(lag_q) << 4)
            + (PROD_W'(lag_q) << 3) + (PROD_W'(lag_q) << 1);
    off     = prod[PROD_W-1:LAG_BITS];
    angle_d = left_first_q ? (8'd90 - off) : (8'd90 + off);
    second_onset = (state_q == WAIT_R) ? onset_r_q : onset_l_q;
  end

  // Event sequencer: wait for both onsets, compute, hand off to UART, then hold off
  always_ff @(posedge clock_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      lag_q        <= '0;
      hold_q       <= '0;
      left_first_q <= 1'b0;
      angle_q      <= 8'd90;
    end else begin
      case (state_q)
        IDLE: begin
          if (onset_l_q && onset_r_q) begin
            lag_q   <= '0;
            state_q <= COMPUTE;
          end else if (onset_l_q) begin
            left_first_q <= 1'b1;
            lag_q        <= '0;
            state_q      <= WAIT_R;
          end else if (onset_r_q) begin
            left_first_q <= 1'b0;
            lag_q        <= '0;
            state_q      <= WAIT_L;
          end
        end
        WAIT_R, WAIT_L: begin
          // the second onset wins over a same-cycle tick, so the pre-increment count is kept
          if (second_onset) begin
            state_q <= COMPUTE;
          end else if (tick_q) begin
            if (lag_q == MAX_LAG) begin
              hold_q  <= '0;
              state_q <= HOLD;
            end else begin
              lag_q <= lag_q + 1'b1;
            end
          end
        end
        COMPUTE: begin
          angle_q <= angle_d;
          state_q <= SEND;
        end
        SEND: begin
          if (!tx_busy_i) begin
            hold_q  <= '0;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (tick_q) begin
            if (hold_q == HOLD_LAST) begin
              hold_q  <= '0;
              lag_q   <= '0;
              state_q <= IDLE;
            end else begin
              hold_q <= hold_q + 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign angle_o     = angle_q;
  assign angle_rdy_o = (state_q == SEND) && !tx_busy_i;
  assign active_o    = (state_q != IDLE);

endmodule

// File: tb/tb_tdoa_angle_estimator.sv
// tb/tb_tdoa_angle_estimator.sv - directed bench for tdoa_angle_estimator
module tb_tdoa_angle_estimator;

  localparam logic [17:0] CL = 18'd7296;
  localparam logic [17:0] CR = 18'd7040;
  localparam int HOLDOFF = 4096;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [17:0] data_l = CL;
  logic        rdy_l = 1'b0;
  logic [17:0] data_r = CR;
  logic        rdy_r = 1'b0;
  logic        tx_busy = 1'b0;
  logic [7:0]  angle;
  logic        angle_rdy;
  logic        active;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  int consec = 0;
  logic prev_rdy = 1'b0;

  tdoa_angle_estimator dut (
    .clock_i      (clk),
    .reset_i      (rst),
    .data_l_i     (data_l),
    .data_rdy_l_i (rdy_l),
    .data_r_i     (data_r),
    .data_rdy_r_i (rdy_r),
    .tx_busy_i    (tx_busy),
    .angle_o      (angle),
    .angle_rdy_o  (angle_rdy),
    .active_o     (active)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (angle_rdy) pulses++;
    if (angle_rdy && prev_rdy) consec++;
    prev_rdy = angle_rdy;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // one-cycle strobe, called and returning at a falling edge
  task automatic strobe(input logic l, input logic [17:0] dl, input logic r, input logic [17:0] dr);
    rdy_l = l; data_l = dl; rdy_r = r; data_r = dr;
    @(negedge clk);
    rdy_l = 1'b0; rdy_r = 1'b0; data_l = CL; data_r = CR;
  endtask

  task automatic ticks(input int n, input logic noisy);
    repeat (n) begin
      strobe(1'b1, noisy ? CL + 18'd3000 : CL, noisy, noisy ? CR + 18'd3000 : CR);
      @(negedge clk);
    end
  endtask

  // call right after the second-channel strobe returns (cycle t+1)
  task automatic expect_event(input string tag, input logic [7:0] exp_angle);
    int p0;
    p0 = pulses;
    chk({tag, "_rdy_t1"}, angle_rdy, 0);
    @(negedge clk);
    chk({tag, "_rdy_t2"}, angle_rdy, 0);
    @(negedge clk);
    chk({tag, "_rdy_t3"}, angle_rdy, 1);
    chk({tag, "_angle"}, angle, exp_angle);
    @(negedge clk);
    chk({tag, "_rdy_t4"}, angle_rdy, 0);
    chk({tag, "_pulses"}, pulses - p0, 1);
  endtask

  task automatic holdoff(input string tag, input logic noisy);
    int p0;
    p0 = pulses;
    ticks(HOLDOFF - 1, noisy);
    chk({tag, "_hold_active"}, active, 1);
    ticks(1, noisy);
    chk({tag, "_hold_done"}, active, 0);
    chk({tag, "_hold_pulses"}, pulses - p0, 0);
  endtask

  initial begin
    int p0;
    repeat (3) @(negedge clk);
    chk("reset_angle", angle, 90);
    chk("reset_rdy", angle_rdy, 0);
    chk("reset_active", active, 0);
    rst = 1'b0;
    @(negedge clk);

    // left first, 8 ticks: off = 720>>4 = 45 -> 90-45
    strobe(1'b1, CL - 18'd3000, 1'b0, CR);
    ticks(8, 1'b0);
    strobe(1'b0, CL, 1'b1, CR + 18'd3000);
    expect_event("left8", 8'd45);
    holdoff("left8", 1'b0);

    // asynchronous reset mid WAIT_R
    strobe(1'b1, CL - 18'd3000, 1'b0, CR);
    ticks(3, 1'b0);
    chk("midwait_active", active, 1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_angle", angle, 90);
    chk("midrst_rdy", angle_rdy, 0);
    chk("midrst_active", active, 0);
    @(negedge clk);
    rst = 1'b0;
    p0 = pulses;
    repeat (10) @(negedge clk);
    chk("postrst_active", active, 0);
    chk("postrst_pulses", pulses - p0, 0);

    // simultaneous onset
    strobe(1'b1, CL + 18'd3000, 1'b1, CR - 18'd3000);
    expect_event("simul", 8'd90);
    holdoff("simul", 1'b0);

    // right first at lag 16 -> 180
    strobe(1'b0, CL, 1'b1, CR + 18'd3000);
    ticks(16, 1'b0);
    strobe(1'b1, CL - 18'd3000, 1'b0, CR);
    expect_event("right16", 8'd180);
    holdoff("right16", 1'b0);

    // right first at lag 1 -> 90 + (90>>4)
    strobe(1'b0, CL, 1'b1, CR + 18'd3000);
    ticks(1, 1'b0);
    strobe(1'b1, CL - 18'd3000, 1'b0, CR);
    expect_event("right1", 8'd95);
    holdoff("right1", 1'b0);

    // timeout: right stays at magnitude 1999 for 17 ticks
    p0 = pulses;
    strobe(1'b1, CL - 18'd3000, 1'b0, CR);
    repeat (17) begin
      strobe(1'b1, CL, 1'b1, CR + 18'd1999);
      @(negedge clk);
    end
    chk("timeout_active", active, 1);
    chk("timeout_angle", angle, 95);
    chk("timeout_pulses", pulses - p0, 0);
    holdoff("timeout", 1'b0);
    chk("timeout_angle_after", angle, 95);

    // busy during SEND, then onsets during holdoff
    tx_busy = 1'b1;
    strobe(1'b1, CL - 18'd3000, 1'b0, CR);
    ticks(8, 1'b0);
    strobe(1'b0, CL, 1'b1, CR + 18'd3000);
    p0 = pulses;
    @(negedge clk);
    @(negedge clk);
    chk("busy_rdy_t3", angle_rdy, 0);
    chk("busy_active", active, 1);
    repeat (50) @(negedge clk);
    chk("busy_pulses", pulses - p0, 0);
    tx_busy = 1'b0;
    #1;
    chk("busy_release_rdy", angle_rdy, 1);
    chk("busy_angle", angle, 45);
    @(negedge clk);
    chk("busy_after_rdy", angle_rdy, 0);
    chk("busy_one_pulse", pulses - p0, 1);
    holdoff("noisyhold", 1'b1);

    // first onset after holdoff is accepted
    strobe(1'b1, CL + 18'd3000, 1'b1, CR - 18'd3000);
    expect_event("afterhold", 8'd90);

    chk("no_consecutive_rdy", consec, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
